// File: rtl/network_sink_pkg.sv
// Shared configuration for the network output sink.
// network_config fixes the network geometry; sink_config derives the packet layout.
// Opcode and index widths are fixed here, and snk_width() sizes the packet for a given run-count width.
package network_config;
  localparam int NET_NUM_OUT = 4;
endpackage

package sink_config;
  import network_config::*;

  localparam int OPC_WIDTH = 2;

  typedef enum logic [OPC_WIDTH-1:0] {
    S_NOP     = 2'd0,
    S_RUN     = 2'd1,
    S_SPK     = 2'd2,
    S_NUM_OPS = 2'd3
  } snk_opcode_t;

  localparam int OUT_IDX_WIDTH = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1;

  // Packet = opcode + a payload field wide enough for either a run count or an output index.
  function automatic int snk_width(input int run_width);
    return OPC_WIDTH + ((run_width > OUT_IDX_WIDTH) ? run_width : OUT_IDX_WIDTH);
  endfunction
endpackage

// File: rtl/network_sink_if.sv
// Network-to-sink and sink-to-host handshake bundle.
// Pure wiring, no latency.
// master drives run data and the consumer ready; slave (the sink) drives net_ready and packets.
interface network_sink_if #(
  parameter int SNK_W = sink_config::snk_width(8)
) ();
  import network_config::*;

  logic                   net_valid;
  logic                   net_ready;
  logic [0:NET_NUM_OUT-1] net_out;
  logic                   out_ready;
  logic                   snk_valid;
  logic                   snk_ready;
  logic [SNK_W-1:0]       snk;

  modport master (
    output net_valid, net_out, out_ready, snk_ready,
    input  net_ready, snk_valid, snk
  );

  modport slave (
    input  net_valid, net_out, out_ready, snk_ready,
    output net_ready, snk_valid, snk
  );
endinterface

// File: rtl/network_sink_prio.sv
// Lowest-set-bit finder over the pending fire mask.
// Combinational, zero latency.
// No backpressure; any=0 means idx is meaningless (driven 0).
module sink_priority_enc
  import network_config::*, sink_config::*;
(
  input  logic [0:NET_NUM_OUT-1]   mask,
  output logic [OUT_IDX_WIDTH-1:0] idx,
  output logic                     any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = NET_NUM_OUT - 1; i >= 0; i--) begin
      if (mask[i]) idx = OUT_IDX_WIDTH'(i);
    end
    any = |mask;
  end

endmodule

// File: rtl/network_sink.sv
// Serializes each captured network run into S_RUN / S_SPK packets; SINK_RLE_EN coalesces empty runs.
// Latency: first packet registered one cycle after the capturing edge; one packet per cycle after that.
// net_ready is low while packets drain; snk is held stable while snk_valid && !snk_ready.
module network_sink
  import network_config::*, sink_config::*;
#(
  parameter int RUN_WIDTH = 8
) (
  input logic           clk,
  input logic           arstn,
  network_sink_if.slave bus
);

  localparam int SW = snk_width(RUN_WIDTH);
  localparam int PW = SW - OPC_WIDTH;

  typedef enum logic [1:0] {IDLE, EMIT_RUN, SCAN} state_t;

  state_t                   state, state_n;
  logic [0:NET_NUM_OUT-1]   fire_mask, fire_mask_n, mask_clr;
  logic [RUN_WIDTH-1:0]     run_val, run_val_n;
  logic                     snk_valid_q, snk_valid_n;
  logic [SW-1:0]            snk_q, snk_n;
  logic [OUT_IDX_WIDTH-1:0] idx_cur, idx_nxt;
  logic                     any_cur, any_nxt;
  logic                     hs, xfer;

`ifdef SINK_RLE_EN
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;
  logic [RUN_WIDTH-1:0] idle_cnt, idle_cnt_n, idle_inc;
`else
  wire unused_out_ready = bus.out_ready;
`endif

  function automatic logic [SW-1:0] pack_run(input logic [RUN_WIDTH-1:0] cnt);
    logic [SW-1:0] p;
    p = '0;
    p[SW-1 -: OPC_WIDTH] = S_RUN;
    p[PW-1 -: RUN_WIDTH] = cnt;
    return p;
  endfunction

  function automatic logic [SW-1:0] pack_spk(input logic [OUT_IDX_WIDTH-1:0] idx);
    logic [SW-1:0] p;
    p = '0;
    p[SW-1 -: OPC_WIDTH]     = S_SPK;
    p[PW-1 -: OUT_IDX_WIDTH] = idx;
    return p;
  endfunction

  assign hs   = bus.net_valid && (state == IDLE);
  assign xfer = snk_valid_q && bus.snk_ready;

  // idx_cur is the packet being shown in SCAN; idx_nxt is what follows once it transfers.
  sink_priority_enc u_enc_cur (.mask(fire_mask), .idx(idx_cur), .any(any_cur));
  sink_priority_enc u_enc_nxt (.mask(mask_clr),  .idx(idx_nxt), .any(any_nxt));

  // Next-state, counters and the next packet to register.
  always_comb begin
    state_n     = state;
    fire_mask_n = fire_mask;
    run_val_n   = run_val;
    snk_valid_n = snk_valid_q;
    snk_n       = snk_q;
    mask_clr    = fire_mask;
    mask_clr[idx_cur] = 1'b0;
`ifdef SINK_RLE_EN
    idle_cnt_n  = idle_cnt;
    idle_inc    = idle_cnt + 1'b1;
`endif
    case (state)
      IDLE: begin
`ifdef SINK_RLE_EN
        if (hs && (|bus.net_out)) begin
          fire_mask_n = bus.net_out;
          run_val_n   = idle_inc;
          idle_cnt_n  = '0;
          state_n     = EMIT_RUN;
        end else if (hs) begin
          if ((idle_inc == RUN_MAX) || bus.out_ready) begin
            run_val_n  = idle_inc;
            idle_cnt_n = '0;
            state_n    = EMIT_RUN;
          end else begin
            idle_cnt_n = idle_inc;
          end
        end else if (bus.out_ready && (idle_cnt != '0)) begin
          run_val_n  = idle_cnt;
          idle_cnt_n = '0;
          state_n    = EMIT_RUN;
        end
`else
        if (hs) begin
          fire_mask_n = bus.net_out;
          run_val_n   = RUN_WIDTH'(1);
          state_n     = EMIT_RUN;
        end
`endif
        if (state_n == EMIT_RUN) begin
          snk_valid_n = 1'b1;
          snk_n       = pack_run(run_val_n);
        end
      end
      EMIT_RUN: begin
        if (xfer) begin
          if (any_cur) begin
            state_n = SCAN;
            snk_n   = pack_spk(idx_cur);
          end else begin
            state_n     = IDLE;
            snk_valid_n = 1'b0;
            snk_n       = '0;
          end
        end else begin
          snk_n = pack_run(run_val);
        end
      end
      SCAN: begin
        if (xfer) begin
          fire_mask_n = mask_clr;
          if (any_nxt) begin
            snk_n = pack_spk(idx_nxt);
          end else begin
            state_n     = IDLE;
            snk_valid_n = 1'b0;
            snk_n       = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and the registered packet output.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      fire_mask   <= '0;
      run_val     <= '0;
      snk_valid_q <= 1'b0;
      snk_q       <= '0;
`ifdef SINK_RLE_EN
      idle_cnt    <= '0;
`endif
    end else begin
      state       <= state_n;
      fire_mask   <= fire_mask_n;
      run_val     <= run_val_n;
      snk_valid_q <= snk_valid_n;
      snk_q       <= snk_n;
`ifdef SINK_RLE_EN
      idle_cnt    <= idle_cnt_n;
`endif
    end
  end

  assign bus.net_ready = (state == IDLE);
  assign bus.snk_valid = snk_valid_q;
  assign bus.snk       = snk_q;

endmodule

// File: tb/tb_network_sink.sv
// Directed bench for network_sink with a packet scoreboard; adapts its model to SINK_RLE_EN.
// Expected packets are queued when runs/flushes are driven and popped at each transfer.
// Also tracks snk stability under stall and the number of cycles net_ready spends low.
module tb_network_sink;
  import network_config::*, sink_config::*;

  localparam int RW = 8;
  localparam int SW = snk_width(RW);

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  network_sink_if #(.SNK_W(SW)) bus ();
  network_sink #(.RUN_WIDTH(RW)) dut (.clk(clk), .arstn(arstn), .bus(bus));

  logic [SW-1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  int nr_low = 0;
  logic stall_prev = 1'b0;
  logic [SW-1:0] snk_prev = '0;
`ifdef SINK_RLE_EN
  int m_idle = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet encodings for 4 outputs, 8-bit run count: 2-bit opcode + 8-bit payload.
  function automatic logic [SW-1:0] p_run(input int c);
    logic [7:0] c8;
    c8 = c[7:0];
    return {2'd1, c8};
  endfunction

  function automatic logic [SW-1:0] p_spk(input int i);
    logic [1:0] i2;
    i2 = i[1:0];
    return {2'd2, i2, 6'd0};
  endfunction

  // b[i] set means output i fires.
  function automatic logic [0:NET_NUM_OUT-1] fires(input logic [3:0] b);
    logic [0:NET_NUM_OUT-1] r;
    for (int i = 0; i < NET_NUM_OUT; i++) r[i] = b[i];
    return r;
  endfunction

  task automatic push_spks(input logic [0:NET_NUM_OUT-1] m);
    for (int i = 0; i < NET_NUM_OUT; i++) if (m[i]) q.push_back(p_spk(i));
  endtask

  task automatic model_capture(input logic [0:NET_NUM_OUT-1] m, input logic fl);
`ifdef SINK_RLE_EN
    if (m != '0) begin
      q.push_back(p_run(m_idle + 1));
      m_idle = 0;
      push_spks(m);
    end else begin
      m_idle++;
      if (m_idle == 255 || fl) begin
        q.push_back(p_run(m_idle));
        m_idle = 0;
      end
    end
`else
    if (fl) q.push_back(p_run(1));
    else    q.push_back(p_run(1));
    push_spks(m);
`endif
  endtask

  task automatic model_flush();
`ifdef SINK_RLE_EN
    if (m_idle > 0) begin
      q.push_back(p_run(m_idle));
      m_idle = 0;
    end
`endif
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!bus.net_ready && w < 200) begin @(posedge clk); #1; w++; end
    chk(tag, bus.net_ready, 1);
  endtask

  task automatic run(input logic [0:NET_NUM_OUT-1] m, input logic fl);
    wait_ready("run_net_ready");
    bus.net_valid = 1'b1;
    bus.net_out   = m;
    bus.out_ready = fl;
    model_capture(m, fl);
    @(posedge clk); #1;
    bus.net_valid = 1'b0;
    bus.net_out   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic flush_pulse();
    wait_ready("flush_net_ready");
    bus.out_ready = 1'b1;
    model_flush();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((q.size() != 0 || !bus.net_ready) && w < 600) begin @(posedge clk); #1; w++; end
    repeat (2) begin @(posedge clk); #1; end
    chk(tag, q.size(), 0);
  endtask

  // Monitor: scoreboard compare on every transfer, stall stability, net_ready low time.
  always @(negedge clk) begin
    if (arstn) begin
      if (!bus.net_ready) nr_low++;
      if (stall_prev) begin
        chk("hold_valid", bus.snk_valid, 1);
        chk("hold_snk", bus.snk, snk_prev);
      end
      if (bus.snk_valid && bus.snk_ready) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_pkt: observed %0h expected none", bus.snk);
        end
        if (q.size() != 0) chk("pkt", bus.snk, q.pop_front());
      end
      stall_prev = bus.snk_valid && !bus.snk_ready;
      snk_prev   = bus.snk;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    bus.net_valid = 1'b0;
    bus.net_out   = '0;
    bus.out_ready = 1'b0;
    bus.snk_ready = 1'b1;

    // 1: reset values, then quiet after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_snk_valid", bus.snk_valid, 0);
    chk("rst_net_ready", bus.net_ready, 1);
    arstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("quiet_snk_valid", bus.snk_valid, 0);
      chk("quiet_snk", bus.snk, 0);
      chk("quiet_net_ready", bus.net_ready, 1);
    end

    // 2: three empty runs then outputs 1 and 3 fire
    nr_low = 0;
    run('0, 1'b0);
    run('0, 1'b0);
    run('0, 1'b0);
    run(fires(4'b1010), 1'b0);
    drain("s2_drain");
`ifdef SINK_RLE_EN
    chk("s2_ready_low", nr_low, 3);
`else
    chk("s2_ready_low", nr_low, 6);
`endif

    // 3: 255 empty runs saturate the counter; the next one counts from 1
    for (int i = 0; i < 255; i++) run('0, 1'b0);
    drain("s3_drain_a");
    run('0, 1'b0);
    flush_pulse();
    drain("s3_drain_b");

    // 4: all outputs fire, consumer stalls 5 cycles on S_SPK 0
    nr_low = 0;
    run(fires(4'b1111), 1'b0);
    @(posedge clk); #1;
    bus.snk_ready = 1'b0;
    chk("s4_spk0_shown", bus.snk, p_spk(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("s4_stall_net_ready", bus.net_ready, 0);
    end
    bus.snk_ready = 1'b1;
    drain("s4_drain");
    chk("s4_ready_low", nr_low, 10);

    // 5: flush semantics
    run('0, 1'b0);
    run('0, 1'b0);
    flush_pulse();
    drain("s5_drain_a");
    flush_pulse();
    repeat (3) begin @(posedge clk); #1; end
    chk("s5_no_pkt", bus.snk_valid, 0);
    run('0, 1'b1);
    drain("s5_drain_b");

    // 6: reset during SCAN after S_SPK 1 has gone
    run(fires(4'b0110), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("s6_spk2_shown", bus.snk, p_spk(2));
    arstn = 1'b0;
    #1;
    q.delete();
`ifdef SINK_RLE_EN
    m_idle = 0;
`endif
    chk("s6_rst_snk_valid", bus.snk_valid, 0);
    chk("s6_rst_snk", bus.snk, 0);
    chk("s6_rst_net_ready", bus.net_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("s6_post_snk_valid", bus.snk_valid, 0);
    end
    run(fires(4'b0001), 1'b0);
    drain("s6_drain");

    repeat (5) begin @(posedge clk); #1; end
    chk("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/network_sink.md
# network_sink

Output stage directly downstream of the network. It captures the per-run output fire vector on every network handshake (`net_valid && net_ready`) and serializes it into opcode-tagged sink packets for the host link. Empty runs are run-length coalesced into a single RUN packet. The block back-pressures the network by deasserting `net_ready` while packets are being drained.

## Interface
Parameters:
- `RUN_WIDTH`, default 8: width of the RUN packet count field; the largest emitted count is 2^RUN_WIDTH−1.
- `NET_NUM_OUT`, no parameter default, taken from `network_config`: number of network outputs.

Ports:
- `clk`  in  1  clock.
- `arstn`  in  1  reset, asynchronous, active-low.
- `net_valid`  in  1  network has run data for this cycle (driven by the source stage).
- `net_ready`  out  1  sink can capture a run; the handshake fires when `net_valid && net_ready`.
- `net_out`  in  [0:NET_NUM_OUT-1]  per-output fire bits; sampled only when the handshake fires.
- `out_ready`  in  1  flush request (the DEC pulse from the source stage).
- `snk_valid`  out  1  `snk` holds a packet.
- `snk_ready`  in  1  consumer accepts the packet.
- `snk`  out  [SNK_WIDTH-1:0]  packet: opcode in the MSBs, then the payload left-aligned, unused LSBs 0.

## Operation
- Opcodes: S_NOP=0, S_RUN=1, S_SPK=2.
- S_RUN payload is the count of runs elapsed. S_SPK payload is the output index. All S_SPK packets belong to the last run counted by the preceding S_RUN.
- FSM states are IDLE, EMIT_RUN and SCAN. `net_ready = (state == IDLE)`.
- IDLE, handshake, `net_out == 0`:
  - Increment `idle_cnt`.
  - If the new value equals 2^RUN_WIDTH−1, or `out_ready` is also high, latch `run_val` = new count, clear `idle_cnt`, and go to EMIT_RUN.
- IDLE, handshake, `net_out != 0`:
  - Latch `fire_mask = net_out` and `run_val = idle_cnt + 1`.
  - Clear `idle_cnt` and go to EMIT_RUN.
  - `idle_cnt` never exceeds 2^RUN_WIDTH−2 in IDLE, so `idle_cnt + 1` cannot overflow.
- IDLE, no handshake, `out_ready`:
  - If `idle_cnt > 0`: `run_val = idle_cnt`, clear `idle_cnt`, go to EMIT_RUN.
  - Otherwise no action.
- `out_ready` outside IDLE is ignored; `idle_cnt` is always 0 there.
- EMIT_RUN:
  - Present S_RUN with `run_val`.
  - On transfer, go to SCAN if `fire_mask != 0`, else go to IDLE.
- SCAN:
  - Present S_SPK carrying the lowest set index of `fire_mask`.
  - On transfer, clear that bit.
  - When the mask becomes 0, go to IDLE.
  - Emission is strictly ascending by index.
- Payload widths:
  - `OUT_IDX_WIDTH = max($clog2(NET_NUM_OUT), 1)`.
  - `SNK_WIDTH = OPC_WIDTH + max(RUN_WIDTH, OUT_IDX_WIDTH)`.

## Timing
- Reset values: `snk_valid = 0`, `snk = 0`, `net_ready = 1`, state IDLE, `idle_cnt = 0`, `fire_mask = 0`, `run_val = 0`.
- `snk` and `snk_valid` are registered. The first packet appears in the cycle after the capturing edge.
- Handshake rules:
  - A packet transfers on `snk_valid && snk_ready`.
  - While `snk_valid && !snk_ready`, `snk` is held stable.
  - `snk_valid` never drops without a transfer.
- With `snk_ready` held high, a run with k fires takes 1 + k cycles outside IDLE. `net_ready` returns high in the cycle after the last transfer.
- Back-to-back packets are allowed: `snk_valid` stays high across transfers with no bubble.
- Reset asserted mid-operation aborts at once to reset values. No partial packet is delivered after reset is released.

## Configuration
- `SINK_RLE_EN` defined:
  - Run-length coalescing as described above.
- `SINK_RLE_EN` undefined:
  - Every captured run goes to EMIT_RUN with `run_val = 1`.
  - `idle_cnt` is not implemented.
  - `out_ready` is ignored.
  - Packet format is unchanged.

## Structure
- Package `sink_config` (imports `network_config`) holds:
  - `snk_opcode_t` (S_NOP, S_RUN, S_SPK, S_NUM_OPS).
  - `OPC_WIDTH`, `OUT_IDX_WIDTH`.
  - A `SNK_WIDTH` helper function of `RUN_WIDTH`.
- Sub-module `sink_priority_enc`: combinational lowest-set-bit index plus `any` flag over `fire_mask`.
- The top level holds the FSM, counters and output register.

## Test plan
All scenarios use NET_NUM_OUT=4, RUN_WIDTH=8, RLE enabled unless noted.
1. Reset release, no stimulus -> `snk_valid = 0`, `snk = 0`, `net_ready = 1` indefinitely.
2. 3 empty runs, then a run with `net_out = 4'b1010`, `snk_ready = 1` -> exactly S_RUN 4, S_SPK 1, S_SPK 3 on consecutive cycles; `net_ready` low for exactly 3 cycles.
3. 255 consecutive empty runs, no flush -> a single S_RUN 255 on run 255; the next empty run restarts counting at 1.
4. Run `net_out = 4'b1111` with `snk_ready` low for 5 cycles during S_SPK 0 -> `snk` held stable; no index skipped or duplicated; `net_ready` stays 0 until S_SPK 3 transfers.
5. 2 empty runs then an `out_ready` pulse -> S_RUN 2. A second `out_ready` with `idle_cnt = 0` -> no packet. An empty run coincident with `out_ready` -> S_RUN 1.
6. `arstn` asserted during SCAN (mask 4'b0110, after S_SPK 1) -> reset values immediately; no S_SPK 2 after release. Repeat scenario 2 with `SINK_RLE_EN` undefined -> four S_RUN 1 packets, then S_SPK 1, S_SPK 3.
